// File: rtl/dmem_pipe_model.sv
// Pipelined fixed-latency data memory model for the LSU.
// Loads and stores run in independent delay pipelines. Each load samples memory
// LD_LATENCY edges after it is accepted. Each store commits ST_LATENCY edges after
// it is accepted. Finished requests wait in in-order response FIFOs until the
// LSU takes them.
// A load that samples on the same edge as a store commit to the same index sees
// the merged (post-store) word.
module dmem_pipe_model #(
    parameter int          MEM_SIZE_KB = 64,
    parameter int          DATA_W      = 64,
    parameter int          LD_LATENCY  = 3,
    parameter int          ST_LATENCY  = 3,
    parameter int          LDTAG_W     = 4,
    parameter int          LD_DEPTH    = 4,
    parameter int          ST_DEPTH    = 2,
    parameter logic [63:0] ERR_DATA    = 64'hDEADBEEF_DEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [31:0]           ld_addr,
    input  logic [LDTAG_W-1:0]    ld_tag,
    output logic                  ld_resp_valid,
    input  logic                  ld_resp_ready,
    output logic [DATA_W-1:0]     ld_resp_data,
    output logic [LDTAG_W-1:0]    ld_resp_tag,
    output logic                  ld_resp_err,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [31:0]           st_addr,
    input  logic [DATA_W-1:0]     st_wdata,
    input  logic [DATA_W/8-1:0]   st_wstrb,
    output logic                  st_resp_valid,
    input  logic                  st_resp_ready,
    output logic                  st_resp_err
);
    localparam int STRB_W    = DATA_W / 8;
    localparam int OFS       = $clog2(STRB_W);
    localparam int MEM_WORDS = MEM_SIZE_KB * 1024 / STRB_W;
    localparam int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int LCNT_W    = $clog2(LD_DEPTH + 1);
    localparam int SCNT_W    = $clog2(ST_DEPTH + 1);
    localparam int LPTR_W    = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int SPTR_W    = (ST_DEPTH > 1) ? $clog2(ST_DEPTH) : 1;
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    if (LD_LATENCY < 1 || ST_LATENCY < 1 || DATA_W < 32 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_param
        $error("dmem_pipe_model: illegal latency or data width parameter");
    end

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < STRB_W; b++)
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic                               ld_acc, ld_pop, st_acc, st_pop;
    logic [LCNT_W-1:0]                  ld_cnt, lf_cnt;
    logic [SCNT_W-1:0]                  st_cnt, sf_cnt;

    logic [LD_LATENCY-1:0]              lp_vld, lp_err;
    logic [LD_LATENCY-1:0][IDX_W-1:0]   lp_idx;
    logic [LD_LATENCY-1:0][LDTAG_W-1:0] lp_tag;
    logic [ST_LATENCY-1:0]              sp_vld, sp_err;
    logic [ST_LATENCY-1:0][IDX_W-1:0]   sp_idx;
    logic [ST_LATENCY-1:0][DATA_W-1:0]  sp_data;
    logic [ST_LATENCY-1:0][STRB_W-1:0]  sp_strb;

    logic                ls_vld, ls_err, st_commit, cm_err;
    logic [IDX_W-1:0]    ls_idx, cm_idx;
    logic [LDTAG_W-1:0]  ls_tag;
    logic [DATA_W-1:0]   ls_word, cm_data, cm_word;
    logic [STRB_W-1:0]   cm_strb;

    logic [DATA_W-1:0]   lf_data [LD_DEPTH];
    logic [LDTAG_W-1:0]  lf_tag  [LD_DEPTH];
    logic                lf_err  [LD_DEPTH];
    logic                sf_err  [ST_DEPTH];
    logic [LPTR_W-1:0]   lf_wr, lf_rd;
    logic [SPTR_W-1:0]   sf_wr, sf_rd;

    assign ld_ready      = (ld_cnt < LCNT_W'(LD_DEPTH));
    assign st_ready      = (st_cnt < SCNT_W'(ST_DEPTH));
    assign ld_acc        = ld_valid && ld_ready;
    assign st_acc        = st_valid && st_ready;
    assign ld_resp_valid = (lf_cnt != '0);
    assign st_resp_valid = (sf_cnt != '0);
    assign ld_pop        = ld_resp_valid && ld_resp_ready;
    assign st_pop        = st_resp_valid && st_resp_ready;
    assign ld_resp_data  = ld_resp_valid ? lf_data[lf_rd] : '0;
    assign ld_resp_tag   = ld_resp_valid ? lf_tag[lf_rd]  : '0;
    assign ld_resp_err   = ld_resp_valid && lf_err[lf_rd];
    assign st_resp_err   = st_resp_valid && sf_err[sf_rd];

    assign ls_vld    = lp_vld[LD_LATENCY-1];
    assign ls_err    = lp_err[LD_LATENCY-1];
    assign ls_idx    = lp_idx[LD_LATENCY-1];
    assign ls_tag    = lp_tag[LD_LATENCY-1];
    assign st_commit = sp_vld[ST_LATENCY-1];
    assign cm_err    = sp_err[ST_LATENCY-1];
    assign cm_idx    = sp_idx[ST_LATENCY-1];
    assign cm_data   = sp_data[ST_LATENCY-1];
    assign cm_strb   = sp_strb[ST_LATENCY-1];
    assign cm_word   = merge_bytes(mem[cm_idx], cm_data, cm_strb);

    // Word seen by the load sampling this edge, including a same-edge store commit.
    always_comb begin
        ls_word = mem[ls_idx];
        if (st_commit && !cm_err && (cm_idx == ls_idx))
            ls_word = merge_bytes(ls_word, cm_data, cm_strb);
        if (ls_err)
            ls_word = ERR_WORD;
    end

    // Request delay pipelines; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_vld <= '0; lp_err <= '0; lp_idx <= '0; lp_tag <= '0;
            sp_vld <= '0; sp_err <= '0; sp_idx <= '0; sp_data <= '0; sp_strb <= '0;
        end else begin
            for (int k = LD_LATENCY - 1; k > 0; k--) begin
                lp_vld[k] <= lp_vld[k-1];
                lp_err[k] <= lp_err[k-1];
                lp_idx[k] <= lp_idx[k-1];
                lp_tag[k] <= lp_tag[k-1];
            end
            lp_vld[0] <= ld_acc;
            lp_err[0] <= (ld_addr >> OFS) >= 32'(MEM_WORDS);
            lp_idx[0] <= IDX_W'(ld_addr >> OFS);
            lp_tag[0] <= ld_tag;
            for (int k = ST_LATENCY - 1; k > 0; k--) begin
                sp_vld[k]  <= sp_vld[k-1];
                sp_err[k]  <= sp_err[k-1];
                sp_idx[k]  <= sp_idx[k-1];
                sp_data[k] <= sp_data[k-1];
                sp_strb[k] <= sp_strb[k-1];
            end
            sp_vld[0]  <= st_acc;
            sp_err[0]  <= (st_addr >> OFS) >= 32'(MEM_WORDS);
            sp_idx[0]  <= IDX_W'(st_addr >> OFS);
            sp_data[0] <= st_wdata;
            sp_strb[0] <= st_wstrb;
        end
    end

    // Outstanding counts and response FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt <= '0; lf_cnt <= '0; lf_wr <= '0; lf_rd <= '0;
            st_cnt <= '0; sf_cnt <= '0; sf_wr <= '0; sf_rd <= '0;
        end else begin
            if (ld_acc && !ld_pop)      ld_cnt <= ld_cnt + 1'b1;
            else if (!ld_acc && ld_pop) ld_cnt <= ld_cnt - 1'b1;
            if (st_acc && !st_pop)      st_cnt <= st_cnt + 1'b1;
            else if (!st_acc && st_pop) st_cnt <= st_cnt - 1'b1;
            if (ls_vld && !ld_pop)      lf_cnt <= lf_cnt + 1'b1;
            else if (!ls_vld && ld_pop) lf_cnt <= lf_cnt - 1'b1;
            if (st_commit && !st_pop)      sf_cnt <= sf_cnt + 1'b1;
            else if (!st_commit && st_pop) sf_cnt <= sf_cnt - 1'b1;
            if (ls_vld)
                lf_wr <= (lf_wr == LPTR_W'(LD_DEPTH - 1)) ? '0 : lf_wr + 1'b1;
            if (ld_pop)
                lf_rd <= (lf_rd == LPTR_W'(LD_DEPTH - 1)) ? '0 : lf_rd + 1'b1;
            if (st_commit)
                sf_wr <= (sf_wr == SPTR_W'(ST_DEPTH - 1)) ? '0 : sf_wr + 1'b1;
            if (st_pop)
                sf_rd <= (sf_rd == SPTR_W'(ST_DEPTH - 1)) ? '0 : sf_rd + 1'b1;
        end
    end

    // Storage without reset: memory contents and FIFO payloads survive rst_n.
    always_ff @(posedge clk) begin
        if (ls_vld) begin
            lf_data[lf_wr] <= ls_word;
            lf_tag[lf_wr]  <= ls_tag;
            lf_err[lf_wr]  <= ls_err;
        end
        if (st_commit)
            sf_err[sf_wr] <= cm_err;
        if (st_commit && !cm_err)
            mem[cm_idx] <= cm_word;
    end
endmodule

// File: tb/tb_dmem_pipe_model.sv
// Directed bench for dmem_pipe_model with default parameters.
module tb_dmem_pipe_model;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0, ld_ready, ld_resp_valid, ld_resp_ready = 1'b1, ld_resp_err;
    logic [31:0] ld_addr = '0;
    logic [3:0]  ld_tag = '0, ld_resp_tag;
    logic [63:0] ld_resp_data;
    logic        st_valid = 1'b0, st_ready, st_resp_valid, st_resp_ready = 1'b1, st_resp_err;
    logic [31:0] st_addr = '0;
    logic [63:0] st_wdata = '0;
    logic [7:0]  st_wstrb = '0;

    int n_vec = 0;
    int n_err = 0;

    dmem_pipe_model dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
        .ld_resp_valid(ld_resp_valid), .ld_resp_ready(ld_resp_ready),
        .ld_resp_data(ld_resp_data), .ld_resp_tag(ld_resp_tag), .ld_resp_err(ld_resp_err),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_wdata(st_wdata),
        .st_wstrb(st_wstrb), .st_resp_valid(st_resp_valid), .st_resp_ready(st_resp_ready),
        .st_resp_err(st_resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            output logic err, output int lat);
        int c;
        st_resp_ready = 1'b1;
        st_addr = a; st_wdata = d; st_wstrb = s; st_valid = 1'b1;
        c = 0;
        while (!st_ready && c < 20) begin tick; c++; end
        if (!st_ready) chk("st_accept_timeout", st_ready, 1);
        tick;
        st_valid = 1'b0;
        lat = 0;
        while (!st_resp_valid && lat < 20) begin tick; lat++; end
        if (!st_resp_valid) chk("st_resp_timeout", st_resp_valid, 1);
        err = st_resp_err;
        tick;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] t,
                           output logic [63:0] d, output logic [3:0] rt, output logic err, output int lat);
        int c;
        ld_resp_ready = 1'b1;
        ld_addr = a; ld_tag = t; ld_valid = 1'b1;
        c = 0;
        while (!ld_ready && c < 20) begin tick; c++; end
        if (!ld_ready) chk("ld_accept_timeout", ld_ready, 1);
        tick;
        ld_valid = 1'b0;
        lat = 0;
        while (!ld_resp_valid && lat < 20) begin tick; lat++; end
        if (!ld_resp_valid) chk("ld_resp_timeout", ld_resp_valid, 1);
        d = ld_resp_data; rt = ld_resp_tag; err = ld_resp_err;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d, d5;
        logic [3:0]  rt;
        logic        e, se;
        int          lat, sl, ll, got, first, extra;

        // reset values
        tick; tick;
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_st_ready", st_ready, 1);
        chk("rst_ld_resp_valid", ld_resp_valid, 0);
        chk("rst_st_resp_valid", st_resp_valid, 0);
        chk("rst_ld_resp_data", ld_resp_data, 0);
        chk("rst_ld_resp_tag", ld_resp_tag, 0);
        chk("rst_ld_resp_err", ld_resp_err, 0);
        chk("rst_st_resp_err", st_resp_err, 0);
        rst_n = 1'b1;
        tick;

        // preload index 2, then single load latency
        do_store(32'h10, 64'h1122334455667788, 8'hFF, e, lat);
        chk("pre_st_err", e, 0);
        chk("pre_st_lat", lat, 3);
        do_load(32'h10, 4'd5, d, rt, e, lat);
        chk("ld1_lat", lat, 3);
        chk("ld1_data", d, 64'h1122334455667788);
        chk("ld1_tag", rt, 5);
        chk("ld1_err", e, 0);
        chk("ld1_consumed", ld_resp_valid, 0);

        // four back-to-back loads
        ld_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pipe_ready", ld_ready, 1);
            ld_valid = 1'b1; ld_addr = 32'(i * 8); ld_tag = 4'(i);
            tick;
        end
        ld_valid = 1'b0;
        got = 0; first = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (ld_resp_valid) begin
                chk("pipe_tag", ld_resp_tag, 64'(got));
                if (got == 0) first = c;
                else chk("pipe_gap", 64'(c - first), 64'(got));
                got++;
            end
            tick;
        end
        chk("pipe_count", got, 4);

        // backpressure: four fill the window, fifth waits
        ld_resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_ready", ld_ready, 1);
            ld_valid = 1'b1; ld_addr = 32'(i * 8); ld_tag = 4'(8 + i);
            tick;
        end
        ld_valid = 1'b1; ld_addr = 32'h10; ld_tag = 4'd12;
        repeat (5) tick;
        chk("bp_full_ready", ld_ready, 0);
        chk("bp_hold_valid", ld_resp_valid, 1);
        chk("bp_hold_tag", ld_resp_tag, 8);
        ld_resp_ready = 1'b1;
        got = 0; d5 = '0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            logic acc;
            if (ld_resp_valid) begin
                chk("bp_tag", ld_resp_tag, 64'(8 + got));
                if (got == 4) d5 = ld_resp_data;
                got++;
            end
            acc = ld_valid && ld_ready;
            tick;
            if (acc) ld_valid = 1'b0;
        end
        chk("bp_count", got, 5);
        chk("bp_data5", d5, 64'h1122334455667788);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            if (ld_resp_valid) extra++;
            tick;
        end
        chk("bp_no_dup", extra, 0);

        // partial store committing on the same edge a load samples
        do_store(32'h0, 64'h0, 8'hFF, e, lat);
        chk("zero_st_err", e, 0);
        chk("fwd_st_ready", st_ready, 1);
        chk("fwd_ld_ready", ld_ready, 1);
        st_valid = 1'b1; st_addr = 32'h0; st_wdata = 64'hAAAA_BBBB_CCCC_DDDD; st_wstrb = 8'h0F;
        ld_valid = 1'b1; ld_addr = 32'h0; ld_tag = 4'd7;
        tick;
        st_valid = 1'b0; ld_valid = 1'b0;
        sl = 0; ll = 0; se = 1'b1; d = '0;
        for (int c = 1; c <= 20 && (sl == 0 || ll == 0); c++) begin
            tick;
            if (st_resp_valid && sl == 0) begin sl = c; se = st_resp_err; end
            if (ld_resp_valid && ll == 0) begin ll = c; d = ld_resp_data; end
        end
        chk("fwd_st_lat", sl, 3);
        chk("fwd_ld_lat", ll, 3);
        chk("fwd_st_err", se, 0);
        chk("fwd_ld_data", d, 64'h0000_0000_CCCC_DDDD);

        // out-of-range load and store
        do_load(32'h10000, 4'd9, d, rt, e, lat);
        chk("oor_ld_data", d, 64'hDEADBEEF_DEADBEEF);
        chk("oor_ld_err", e, 1);
        chk("oor_ld_tag", rt, 9);
        do_store(32'h10000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, e, lat);
        chk("oor_st_err", e, 1);
        do_load(32'h0, 4'd3, d, rt, e, lat);
        chk("oor_mem_kept", d, 64'h0000_0000_CCCC_DDDD);
        chk("oor_mem_err", e, 0);

        // reset with two loads and a store in flight
        ld_resp_ready = 1'b1; st_resp_ready = 1'b1;
        ld_valid = 1'b1; ld_addr = 32'h10; ld_tag = 4'd1;
        st_valid = 1'b1; st_addr = 32'h10; st_wdata = 64'h0; st_wstrb = 8'hFF;
        tick;
        st_valid = 1'b0; ld_tag = 4'd2;
        tick;
        ld_valid = 1'b0;
        tick;
        rst_n = 1'b0;
        tick; tick;
        chk("mid_rst_ld_ready", ld_ready, 1);
        chk("mid_rst_st_ready", st_ready, 1);
        rst_n = 1'b1;
        extra = 0; got = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (ld_resp_valid) extra++;
            if (st_resp_valid) got++;
        end
        chk("post_rst_no_ld_resp", extra, 0);
        chk("post_rst_no_st_resp", got, 0);
        chk("post_rst_ld_ready", ld_ready, 1);
        chk("post_rst_st_ready", st_ready, 1);
        do_load(32'h10, 4'd4, d, rt, e, lat);
        chk("post_rst_mem", d, 64'h1122334455667788);
        chk("post_rst_tag", rt, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_pipe_model.md
Name: dmem_pipe_model

Overview:
Parametrised, pipelined fixed-latency data memory model. It is the successor to the single-request stall-based dmem model for the OoO core's LSU.
- Supports up to LD_DEPTH outstanding loads and ST_DEPTH outstanding stores, each at one request per cycle.
- Configurable data width.
- Explicit error responses.
- Defined store-to-load visibility ordering.

Parameters:
MEM_SIZE_KB, 64, memory size in KiB.
DATA_W, 64, data word width in bits; power of two, at least 32; STRB_W = DATA_W/8, OFS = log2(STRB_W).
LD_LATENCY, 3, cycles from load accept edge to response; at least 1.
ST_LATENCY, 3, cycles from store accept edge to commit and response; at least 1.
LDTAG_W, 4, load tag width.
LD_DEPTH, 4, maximum loads accepted but not yet handed off (in flight plus queued responses).
ST_DEPTH, 2, maximum stores accepted but whose response has not yet been handed off.
ERR_DATA, 64'hDEADBEEF_DEADBEEF, data returned on an out-of-range load (low DATA_W bits used).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
ld_valid  in  1  load request valid
ld_ready  out  1  load request accept
ld_addr  in  32  load byte address
ld_tag  in  LDTAG_W  load tag
ld_resp_valid  out  1  load response valid
ld_resp_ready  in  1  LSU accepts load response
ld_resp_data  out  DATA_W  load data (full word)
ld_resp_tag  out  LDTAG_W  tag of responding load
ld_resp_err  out  1  address out of range
st_valid  in  1  store request valid
st_ready  out  1  store request accept
st_addr  in  32  store byte address
st_wdata  in  DATA_W  store data
st_wstrb  in  STRB_W  byte enables
st_resp_valid  out  1  store completion valid
st_resp_ready  in  1  LSU accepts completion
st_resp_err  out  1  store address out of range (write dropped)

Behaviour:
- Clock and reset: clk is the clock. rst_n is the reset: asynchronous, active-low.
- Reset values:
  - All outputs 0 except ld_ready=1 and st_ready=1.
  - All in-flight and queued requests are discarded.
  - Memory contents are NOT reset.
  - Reset mid-operation gives no response for any discarded request.
- Addressing:
  - index = addr >> OFS; low OFS bits are ignored (no misalignment error).
  - Out of range when index >= MEM_SIZE_KB*1024/STRB_W.
- Load channel:
  - Accept on ld_valid && ld_ready at edge E0.
  - ld_ready = (ld_cnt < LD_DEPTH), purely from the registered count; there is no same-cycle pop-through when full.
  - ld_cnt: +1 on accept, -1 on the response handshake (ld_resp_valid && ld_resp_ready); both in one cycle leaves it unchanged.
  - The load samples memory at edge E0+LD_LATENCY.
  - Responses are strictly in accept order through an internal response FIFO of LD_DEPTH entries.
  - With the FIFO empty, ld_resp_valid rises after edge E0+LD_LATENCY. Otherwise the response waits behind older entries.
  - ld_resp_valid/data/tag/err hold stable until the handshake.
  - Back-to-back accepts with ld_resp_ready=1 sustain 1 response/cycle.
  - Out-of-range load: data=ERR_DATA, err=1.
- Store channel:
  - Accept on st_valid && st_ready at edge E0.
  - st_ready = (st_cnt < ST_DEPTH); st_cnt uses the same +1/-1 rule as ld_cnt, decremented on the st_resp handshake.
  - Commit at edge E0+ST_LATENCY as a byte-wise read-modify-write under wstrb. wstrb=0 writes nothing but still responds.
  - Completions are queued in order. With the queue empty, st_resp_valid rises after the commit edge and holds until st_resp_ready.
  - Out of range: write dropped, st_resp_err=1.
- Ordering and forwarding:
  - A load sampling at the same edge as a store commit to the same index returns the merged (post-store) bytes.
  - A load sampling after the commit edge sees the store; a load sampling before it does not.
  - Stores commit in accept order. Two stores cannot commit on the same edge, since each channel accepts at most one request per cycle.
- Loads and stores are independent and may be accepted on the same cycle.
- Simulation assertion: LD_LATENCY >= 1, ST_LATENCY >= 1, DATA_W a power of two and at least 32.

Test Plan:
- Single load latency: preload index 2 = 64'h1122334455667788; ld_addr=0x10, tag=5, ld_resp_ready=1 → ld_resp_valid exactly 3 cycles after the accept edge, data=64'h1122334455667788, tag=5, err=0.
- Pipelined loads: 4 back-to-back loads, tags 0-3, ld_resp_ready=1 → ld_ready stays 1, responses on 4 consecutive cycles in tag order 0,1,2,3.
- Backpressure and full: ld_resp_ready=0, issue 5 loads → ld_ready drops after the 4th accept and the 5th is held. Raise ld_resp_ready → 4 responses in order, the 5th is accepted and returns afterwards. Data is never dropped or duplicated.
- Store strobe and forwarding: mem[0]=0; store addr=0, wdata=64'hAAAA_BBBB_CCCC_DDDD, wstrb=8'h0F, accepted on the same edge as a load to addr=0 (both latency 3) → st_resp_valid after edge +3; load returns 64'h0000_0000_CCCC_DDDD.
- Out of range: ld_addr=0x10000 → data=DEADBEEFDEADBEEF, err=1. Store to 0x10000 → st_resp_err=1, memory unchanged.
- Reset mid-flight: assert rst_n=0 two cycles after accepting 2 loads and 1 store → no responses after release, ld_ready=st_ready=1, prior memory contents retained.
